// File: rtl/multicycle_ctrl.sv
// Multicycle control FSM: sequences fetch/decode/execute/memory/writeback,
// holds the NZCV flag register and evaluates the instruction condition field.
module multicycle_ctrl #(
  parameter int unsigned FETCH_WAIT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] cond,
  input  logic [1:0] op,
  input  logic       funct_i,
  input  logic [3:0] opcode,
  input  logic       funct_s,
  input  logic       funct_l,
  input  logic [3:0] rd,
  input  logic [3:0] alu_flags,
  input  logic       mem_ready,
  output logic       pc_en,
  output logic       pc_load,
  output logic       ir_we,
  output logic       we_RF,
  output logic       mem_re,
  output logic       mem_we,
  output logic       alu_src_b,
  output logic [2:0] alu_ctrl,
  output logic       result_src,
  output logic [3:0] flags,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_EXEC    = 4'd2,
    S_WB_ALU  = 4'd3,
    S_MEM_ADR = 4'd4,
    S_MEM_RD  = 4'd5,
    S_MEM_WR  = 4'd6,
    S_WB_MEM  = 4'd7,
    S_BRANCH  = 4'd8
  } state_t;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_ORR = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b011;
  localparam logic [2:0] ALU_MOV = 3'b100;

  state_t     cur, nxt;
  logic [1:0] wcnt;
  logic       fetch_done;
  logic       cond_ok;
  logic       dp_ok;
  logic [2:0] dp_alu;
  logic       is_cmp;
  logic       fn, fz, fc, fv;

  assign state      = cur;
  assign fetch_done = (wcnt == 2'(FETCH_WAIT));
  assign is_cmp     = (opcode == 4'b1010);
  assign {fn, fz, fc, fv} = flags;

  always_comb begin
    cond_ok = 1'b0;
    case (cond)
      4'b0000: cond_ok = fz;
      4'b0001: cond_ok = !fz;
      4'b0010: cond_ok = fc;
      4'b0011: cond_ok = !fc;
      4'b0100: cond_ok = fn;
      4'b0101: cond_ok = !fn;
      4'b0110: cond_ok = fv;
      4'b0111: cond_ok = !fv;
      4'b1000: cond_ok = fc && !fz;
      4'b1001: cond_ok = !fc || fz;
      4'b1010: cond_ok = (fn == fv);
      4'b1011: cond_ok = (fn != fv);
      4'b1100: cond_ok = !fz && (fn == fv);
      4'b1101: cond_ok = fz || (fn != fv);
      default: cond_ok = 1'b1;
    endcase
  end

  always_comb begin
    dp_ok  = 1'b1;
    dp_alu = ALU_AND;
    case (opcode)
      4'b0000: dp_alu = ALU_AND;
      4'b1100: dp_alu = ALU_ORR;
      4'b0100: dp_alu = ALU_ADD;
      4'b0010: dp_alu = ALU_SUB;
      4'b1010: dp_alu = ALU_SUB;
      4'b1101: dp_alu = ALU_MOV;
      default: dp_ok  = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cur   <= S_FETCH;
      wcnt  <= '0;
      flags <= '0;
    end else begin
      cur <= nxt;
      if (cur == S_FETCH && !fetch_done)
        wcnt <= wcnt + 2'd1;
      else
        wcnt <= '0;
      if (cur == S_EXEC && (funct_s || is_cmp))
        flags <= alu_flags;
    end
  end

  // ir_we/pc_en are gated by rst so a FETCH_WAIT=0 build stays quiet in reset.
  always_comb begin
    nxt        = cur;
    pc_en      = 1'b0;
    ir_we      = 1'b0;
    pc_load    = 1'b0;
    we_RF      = 1'b0;
    mem_re     = 1'b0;
    mem_we     = 1'b0;
    alu_src_b  = 1'b0;
    alu_ctrl   = ALU_AND;
    result_src = 1'b0;
    illegal    = 1'b0;
    case (cur)
      S_FETCH: begin
        if (fetch_done) begin
          ir_we = rst;
          pc_en = rst;
          nxt   = S_DECODE;
        end
      end
      S_DECODE: begin
        nxt = S_FETCH;
        if (cond == 4'b1111 || op == 2'b11)
          illegal = 1'b1;
        else if (op == 2'b00 && (!dp_ok || (rd == 4'd15 && !is_cmp)))
          illegal = 1'b1;
        else if (cond_ok) begin
          case (op)
            2'b00:   nxt = S_EXEC;
            2'b01:   nxt = S_MEM_ADR;
            default: nxt = S_BRANCH;
          endcase
        end
      end
      S_EXEC: begin
        alu_src_b = funct_i;
        alu_ctrl  = dp_alu;
        nxt       = is_cmp ? S_FETCH : S_WB_ALU;
      end
      S_WB_ALU: begin
        we_RF = 1'b1;
        nxt   = S_FETCH;
      end
      S_MEM_ADR: begin
        alu_src_b = 1'b1;
        alu_ctrl  = ALU_ADD;
        nxt       = funct_l ? S_MEM_RD : S_MEM_WR;
      end
      S_MEM_RD: begin
        mem_re = 1'b1;
        if (mem_ready) nxt = S_WB_MEM;
      end
      S_MEM_WR: begin
        mem_we = 1'b1;
        if (mem_ready) nxt = S_FETCH;
      end
      S_WB_MEM: begin
        we_RF      = 1'b1;
        result_src = 1'b1;
        nxt        = S_FETCH;
      end
      S_BRANCH: begin
        pc_load   = 1'b1;
        alu_src_b = 1'b1;
        alu_ctrl  = ALU_ADD;
        nxt       = S_FETCH;
      end
      default: nxt = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: table of single-instruction vectors with expected
// per-instruction activity, plus sequences for reset aborts and FETCH_WAIT=0.
module tb_multicycle_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] cond = 4'b1110;
  logic [1:0] op = 2'b00;
  logic       funct_i = 1'b0;
  logic [3:0] opcode = 4'b0100;
  logic       funct_s = 1'b0;
  logic       funct_l = 1'b0;
  logic [3:0] rd = 4'd1;
  logic [3:0] alu_flags = 4'b0000;
  logic       mem_ready = 1'b0;

  logic       pc_en, pc_load, ir_we, we_RF, mem_re, mem_we, alu_src_b, result_src, illegal;
  logic [2:0] alu_ctrl;
  logic [3:0] flags, state;
  logic       pc_en0, pc_load0, ir_we0, we_RF0, mem_re0, mem_we0, alu_src_b0, result_src0, illegal0;
  logic [2:0] alu_ctrl0;
  logic [3:0] flags0, state0;

  localparam logic [3:0] ST_FETCH = 4'd0, ST_DECODE = 4'd1, ST_EXEC = 4'd2, ST_WB_ALU = 4'd3,
                         ST_MEM_ADR = 4'd4, ST_MEM_RD = 4'd5, ST_MEM_WR = 4'd6, ST_BRANCH = 4'd8;

  multicycle_ctrl #(.FETCH_WAIT(1)) dut (
    .clk(clk), .rst(rst), .cond(cond), .op(op), .funct_i(funct_i), .opcode(opcode),
    .funct_s(funct_s), .funct_l(funct_l), .rd(rd), .alu_flags(alu_flags), .mem_ready(mem_ready),
    .pc_en(pc_en), .pc_load(pc_load), .ir_we(ir_we), .we_RF(we_RF), .mem_re(mem_re),
    .mem_we(mem_we), .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl), .result_src(result_src),
    .flags(flags), .illegal(illegal), .state(state)
  );

  multicycle_ctrl #(.FETCH_WAIT(0)) dut0 (
    .clk(clk), .rst(rst), .cond(cond), .op(op), .funct_i(funct_i), .opcode(opcode),
    .funct_s(funct_s), .funct_l(funct_l), .rd(rd), .alu_flags(alu_flags), .mem_ready(mem_ready),
    .pc_en(pc_en0), .pc_load(pc_load0), .ir_we(ir_we0), .we_RF(we_RF0), .mem_re(mem_re0),
    .mem_we(mem_we0), .alu_src_b(alu_src_b0), .alu_ctrl(alu_ctrl0), .result_src(result_src0),
    .flags(flags0), .illegal(illegal0), .state(state0)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] cond;  logic [1:0] op;  logic fi;  logic [3:0] opc;  logic fs;  logic fl;
    logic [3:0] rd;    logic [3:0] af;  int dly;   logic noise;
    int e_cyc; int e_we; logic e_res; int e_re; int e_wr; int e_pcl; int e_ill;
    logic [2:0] e_alu; logic e_srcb; logic [3:0] e_flags;
  } vec_t;

  vec_t vecs[$];
  int n_chk = 0;
  int n_fail = 0;

  function automatic vec_t mk(input logic [3:0] c, input logic [1:0] o, input logic fi,
                              input logic [3:0] opc, input logic fs, input logic fl,
                              input logic [3:0] r, input logic [3:0] af, input int dly,
                              input logic noise, input int cyc, input int we, input logic res,
                              input int re, input int wr, input int pcl, input int ill,
                              input logic [2:0] alu, input logic srcb, input logic [3:0] fl_e);
    vec_t v;
    v.cond = c; v.op = o; v.fi = fi; v.opc = opc; v.fs = fs; v.fl = fl; v.rd = r; v.af = af;
    v.dly = dly; v.noise = noise; v.e_cyc = cyc; v.e_we = we; v.e_res = res; v.e_re = re;
    v.e_wr = wr; v.e_pcl = pcl; v.e_ill = ill; v.e_alu = alu; v.e_srcb = srcb; v.e_flags = fl_e;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [10:0] outs_main();
    return {pc_en, pc_load, ir_we, we_RF, mem_re, mem_we, alu_src_b, alu_ctrl, result_src};
  endfunction

  // Runs one instruction starting at the first FETCH cycle; stops at the next one.
  task automatic run(input int idx, input vec_t v);
    int cycles = 0, we_n = 0, we_cyc = 0, re_n = 0, wr_n = 0, pcl_n = 0, ill_n = 0;
    int ir_cyc = 0, pcen_n = 0, waits = 0;
    logic res = 1'b0, srcb = 1'b0, done = 1'b0;
    logic [2:0] alu = 3'b111;
    logic [3:0] prev = ST_FETCH;
    cond = v.cond; op = v.op; funct_i = v.fi; opcode = v.opc; funct_s = v.fs;
    funct_l = v.fl; rd = v.rd; alu_flags = v.af;
    for (int k = 0; k < 60 && !done; k++) begin
      if (k > 0 && state == ST_FETCH && prev != ST_FETCH) done = 1'b1;
      else begin
        cycles++;
        if (ir_we && ir_cyc == 0) ir_cyc = cycles;
        if (pc_en) pcen_n++;
        if (we_RF) begin we_n++; we_cyc = cycles; res = result_src; end
        if (mem_re) re_n++;
        if (mem_we) wr_n++;
        if (pc_load) pcl_n++;
        if (illegal) ill_n++;
        if (state == ST_EXEC || state == ST_MEM_ADR || state == ST_BRANCH) begin
          alu = alu_ctrl; srcb = alu_src_b;
        end
        if (state == ST_MEM_RD || state == ST_MEM_WR) begin
          mem_ready = (waits == v.dly);
          waits++;
        end else mem_ready = v.noise;
        prev = state;
        @(negedge clk);
      end
    end
    mem_ready = 1'b0;
    chk($sformatf("v%0d done", idx), {31'd0, done}, 32'd1);
    chk($sformatf("v%0d cycles", idx), cycles, v.e_cyc);
    chk($sformatf("v%0d ir_we_cycle", idx), ir_cyc, 2);
    chk($sformatf("v%0d pc_en_count", idx), pcen_n, 1);
    chk($sformatf("v%0d we_RF_count", idx), we_n, v.e_we);
    chk($sformatf("v%0d we_RF_cycle", idx), we_cyc, (v.e_we != 0) ? v.e_cyc : 0);
    chk($sformatf("v%0d result_src", idx), {31'd0, res}, {31'd0, v.e_res});
    chk($sformatf("v%0d mem_re_count", idx), re_n, v.e_re);
    chk($sformatf("v%0d mem_we_count", idx), wr_n, v.e_wr);
    chk($sformatf("v%0d pc_load_count", idx), pcl_n, v.e_pcl);
    chk($sformatf("v%0d illegal_count", idx), ill_n, v.e_ill);
    chk($sformatf("v%0d alu_ctrl", idx), {29'd0, alu}, {29'd0, v.e_alu});
    chk($sformatf("v%0d alu_src_b", idx), {31'd0, srcb}, {31'd0, v.e_srcb});
    chk($sformatf("v%0d flags", idx), {28'd0, flags}, {28'd0, v.e_flags});
  endtask

  task automatic wait_state(input logic [3:0] s, input string name);
    logic hit = 1'b0;
    for (int k = 0; k < 20 && !hit; k++) begin
      if (state == s) hit = 1'b1;
      else @(negedge clk);
    end
    chk({name, " reached"}, {31'd0, hit}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //        cond    op    i    opc     s    l    rd     af     dly n  | cyc we res re wr pcl ill alu    srcb flags
    vecs.push_back(mk(4'b1110,2'b00,1'b0,4'b0100,1'b0,1'b0,4'd1, 4'b1111,0,1'b0, 5,1,1'b0,0,0,0,0,3'b010,1'b0,4'b0000));
    vecs.push_back(mk(4'b1110,2'b00,1'b1,4'b0010,1'b1,1'b0,4'd2, 4'b0100,0,1'b0, 5,1,1'b0,0,0,0,0,3'b011,1'b1,4'b0100));
    vecs.push_back(mk(4'b0000,2'b10,1'b0,4'b0000,1'b0,1'b0,4'd0, 4'b0000,0,1'b0, 4,0,1'b0,0,0,1,0,3'b010,1'b1,4'b0100));
    vecs.push_back(mk(4'b0001,2'b10,1'b0,4'b0000,1'b0,1'b0,4'd0, 4'b0000,0,1'b0, 3,0,1'b0,0,0,0,0,3'b111,1'b0,4'b0100));
    vecs.push_back(mk(4'b1110,2'b01,1'b1,4'b0000,1'b0,1'b1,4'd3, 4'b0000,3,1'b0, 9,1,1'b1,4,0,0,0,3'b010,1'b1,4'b0100));
    vecs.push_back(mk(4'b1110,2'b01,1'b1,4'b0000,1'b0,1'b0,4'd3, 4'b0000,0,1'b0, 5,0,1'b0,0,1,0,0,3'b010,1'b1,4'b0100));
    vecs.push_back(mk(4'b1110,2'b11,1'b0,4'b0100,1'b0,1'b0,4'd1, 4'b0000,0,1'b0, 3,0,1'b0,0,0,0,1,3'b111,1'b0,4'b0100));
    vecs.push_back(mk(4'b1111,2'b00,1'b0,4'b0100,1'b0,1'b0,4'd1, 4'b0000,0,1'b0, 3,0,1'b0,0,0,0,1,3'b111,1'b0,4'b0100));
    vecs.push_back(mk(4'b1110,2'b00,1'b1,4'b1101,1'b0,1'b0,4'd15,4'b0000,0,1'b0, 3,0,1'b0,0,0,0,1,3'b111,1'b0,4'b0100));
    vecs.push_back(mk(4'b1110,2'b00,1'b0,4'b1010,1'b0,1'b0,4'd0, 4'b1000,0,1'b0, 4,0,1'b0,0,0,0,0,3'b011,1'b0,4'b1000));
    vecs.push_back(mk(4'b1010,2'b00,1'b1,4'b1101,1'b0,1'b0,4'd4, 4'b0000,0,1'b0, 3,0,1'b0,0,0,0,0,3'b111,1'b0,4'b1000));
    vecs.push_back(mk(4'b1011,2'b00,1'b1,4'b1101,1'b0,1'b0,4'd4, 4'b0000,0,1'b0, 5,1,1'b0,0,0,0,0,3'b100,1'b1,4'b1000));
    vecs.push_back(mk(4'b0100,2'b00,1'b0,4'b1100,1'b0,1'b0,4'd5, 4'b0000,0,1'b0, 5,1,1'b0,0,0,0,0,3'b001,1'b0,4'b1000));
    vecs.push_back(mk(4'b1110,2'b00,1'b0,4'b0001,1'b0,1'b0,4'd5, 4'b0000,0,1'b0, 3,0,1'b0,0,0,0,1,3'b111,1'b0,4'b1000));
    vecs.push_back(mk(4'b1110,2'b01,1'b1,4'b0000,1'b0,1'b1,4'd6, 4'b0000,1,1'b1, 7,1,1'b1,2,0,0,0,3'b010,1'b1,4'b1000));
    vecs.push_back(mk(4'b1000,2'b00,1'b0,4'b0100,1'b0,1'b0,4'd1, 4'b0000,0,1'b0, 3,0,1'b0,0,0,0,0,3'b111,1'b0,4'b1000));
    vecs.push_back(mk(4'b1110,2'b00,1'b1,4'b1010,1'b0,1'b0,4'd0, 4'b0010,0,1'b0, 4,0,1'b0,0,0,0,0,3'b011,1'b1,4'b0010));
    vecs.push_back(mk(4'b1000,2'b00,1'b0,4'b0100,1'b0,1'b0,4'd1, 4'b0000,0,1'b0, 5,1,1'b0,0,0,0,0,3'b010,1'b0,4'b0010));
    vecs.push_back(mk(4'b1001,2'b00,1'b0,4'b0100,1'b0,1'b0,4'd1, 4'b0000,0,1'b0, 3,0,1'b0,0,0,0,0,3'b111,1'b0,4'b0010));
    vecs.push_back(mk(4'b1100,2'b00,1'b0,4'b0100,1'b0,1'b0,4'd1, 4'b0000,0,1'b0, 5,1,1'b0,0,0,0,0,3'b010,1'b0,4'b0010));
    vecs.push_back(mk(4'b1101,2'b00,1'b0,4'b0100,1'b0,1'b0,4'd1, 4'b0000,0,1'b0, 3,0,1'b0,0,0,0,0,3'b111,1'b0,4'b0010));
    vecs.push_back(mk(4'b1110,2'b00,1'b0,4'b0100,1'b1,1'b0,4'd1, 4'b1001,0,1'b0, 5,1,1'b0,0,0,0,0,3'b010,1'b0,4'b1001));
    vecs.push_back(mk(4'b0110,2'b10,1'b0,4'b0000,1'b0,1'b0,4'd0, 4'b0000,0,1'b0, 4,0,1'b0,0,0,1,0,3'b010,1'b1,4'b1001));
    vecs.push_back(mk(4'b0011,2'b10,1'b0,4'b0000,1'b0,1'b0,4'd0, 4'b0000,0,1'b0, 4,0,1'b0,0,0,1,0,3'b010,1'b1,4'b1001));
    vecs.push_back(mk(4'b0010,2'b10,1'b0,4'b0000,1'b0,1'b0,4'd0, 4'b0000,0,1'b0, 3,0,1'b0,0,0,0,0,3'b111,1'b0,4'b1001));
    vecs.push_back(mk(4'b1110,2'b00,1'b0,4'b1010,1'b0,1'b0,4'd15,4'b0000,0,1'b0, 4,0,1'b0,0,0,0,0,3'b011,1'b0,4'b0000));
    vecs.push_back(mk(4'b1110,2'b00,1'b1,4'b0100,1'b1,1'b0,4'd2, 4'b0110,0,1'b0, 5,1,1'b0,0,0,0,0,3'b010,1'b1,4'b0110));
    vecs.push_back(mk(4'b1110,2'b01,1'b1,4'b0000,1'b0,1'b0,4'd3, 4'b0000,2,1'b1, 7,0,1'b0,0,3,0,0,3'b010,1'b1,4'b0110));

    // Reset held three cycles with an ADD presented.
    repeat (3) @(negedge clk);
    chk("reset state", {28'd0, state}, {28'd0, ST_FETCH});
    chk("reset flags", {28'd0, flags}, 32'd0);
    chk("reset outputs", {20'd0, outs_main(), illegal}, 32'd0);
    chk("reset ir_we fw0", {31'd0, ir_we0}, 32'd0);
    rst = 1'b1;

    foreach (vecs[i]) run(i, vecs[i]);

    // Reset while waiting in MEM_RD: abort immediately, no writeback afterwards.
    cond = 4'b1110; op = 2'b01; funct_l = 1'b1; funct_i = 1'b1; mem_ready = 1'b0;
    wait_state(ST_MEM_RD, "mem_rd");
    chk("mem_rd mem_re", {31'd0, mem_re}, 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("abort mem_rd state", {28'd0, state}, {28'd0, ST_FETCH});
    chk("abort mem_rd outputs", {20'd0, outs_main(), illegal}, 32'd0);
    chk("abort mem_rd flags", {28'd0, flags}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Reset during an EXEC that would set flags: flags must remain cleared.
    op = 2'b00; opcode = 4'b0100; funct_s = 1'b1; alu_flags = 4'b1111; rd = 4'd1;
    wait_state(ST_EXEC, "exec");
    #2 rst = 1'b0;
    #1;
    chk("abort exec state", {28'd0, state}, {28'd0, ST_FETCH});
    @(negedge clk);
    chk("abort exec flags", {28'd0, flags}, 32'd0);
    chk("abort exec outputs", {20'd0, outs_main(), illegal}, 32'd0);
    funct_s = 1'b0;

    // FETCH_WAIT=0 build: ADD completes in 4 cycles.
    repeat (2) @(negedge clk);
    chk("fw0 reset ir_we", {31'd0, ir_we0}, 32'd0);
    rst = 1'b1;
    #1;
    chk("fw0 c1 state", {28'd0, state0}, {28'd0, ST_FETCH});
    chk("fw0 c1 ir_we/pc_en", {30'd0, ir_we0, pc_en0}, 32'd3);
    @(negedge clk);
    chk("fw0 c2 state", {28'd0, state0}, {28'd0, ST_DECODE});
    @(negedge clk);
    chk("fw0 c3 state", {28'd0, state0}, {28'd0, ST_EXEC});
    @(negedge clk);
    chk("fw0 c4 state", {28'd0, state0}, {28'd0, ST_WB_ALU});
    chk("fw0 c4 we_RF", {31'd0, we_RF0}, 32'd1);
    @(negedge clk);
    chk("fw0 c5 state", {28'd0, state0}, {28'd0, ST_FETCH});

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multicycle control FSM for the ARM-style processor core.
- Sequences the instruction ROM/PC counter fetch, the decoder fields, the register bank write port, the ALU and the data-memory handshake.
- Holds the NZCV flag register and evaluates each instruction's condition field.
- Sits between the decoder outputs and the enables/selects of the counter, instruction register, register bank, muxes and data memory.

Parameters:
FETCH_WAIT, 1, ROM read latency in cycles (registered ROM = 1); range 0..3.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
cond  in  4  decoded condition field
op  in  2  decoded Op field: 00 data-proc, 01 memory, 10 branch, 11 illegal
funct_i  in  1  immediate-operand bit
opcode  in  4  data-proc opcode
funct_s  in  1  set-flags bit
funct_l  in  1  load(1)/store(0) bit
rd  in  4  destination register index
alu_flags  in  4  NZCV from ALU, valid in EXEC
mem_ready  in  1  data memory completion, sampled in MEM_RD/MEM_WR
pc_en  out  1  counter increment enable
pc_load  out  1  counter load branch target
ir_we  out  1  instruction register capture
we_RF  out  1  register bank write enable
mem_re  out  1  data memory read request
mem_we  out  1  data memory write request
alu_src_b  out  1  1 = immediate/offset, 0 = register
alu_ctrl  out  3  000 AND, 001 ORR, 010 ADD, 011 SUB, 100 MOV (pass B)
result_src  out  1  0 = ALU result, 1 = memory read data
flags  out  4  NZCV register
illegal  out  1  one-cycle pulse on undefined instruction
state  out  4  current state, debug

Behaviour:
- Reset (rst=0, async): state=FETCH, wait counter=0, flags=0000, all outputs 0. Reset mid-instruction aborts it; no partial write survives.
- States: FETCH, DECODE, EXEC, WB_ALU, MEM_ADR, MEM_RD, MEM_WR, WB_MEM, BRANCH.
- FETCH:
  - Wait counter counts 0..FETCH_WAIT.
  - On count==FETCH_WAIT: ir_we=1 and pc_en=1 for one cycle, then go to DECODE.
  - FETCH lasts FETCH_WAIT+1 cycles.
- DECODE: one cycle; the condition check uses the current flags register.
  - Condition codes: EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V; HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V); AL 1.
  - cond=1111 or op=11: illegal pulse, return to FETCH.
  - Data-proc with unsupported opcode, or rd==15 and opcode!=CMP: illegal pulse, return to FETCH.
  - Condition false: return to FETCH, no side effects.
  - Otherwise: op 00 -> EXEC, 01 -> MEM_ADR, 10 -> BRANCH.
- Opcode map: 0000 AND, 1100 ORR, 0100 ADD, 0010 SUB, 1010 CMP (alu_ctrl SUB, no write), 1101 MOV.
- EXEC:
  - alu_src_b=funct_i; alu_ctrl per opcode.
  - flags<=alu_flags at the clock edge ending EXEC if funct_s=1 or opcode==CMP.
  - CMP -> FETCH; else -> WB_ALU.
- WB_ALU: we_RF=1, result_src=0, one cycle -> FETCH.
- MEM_ADR: alu_src_b=1, alu_ctrl=ADD (or SUB when funct_i=0 is not used; offset is always immediate). funct_l=1 -> MEM_RD, else MEM_WR.
- MEM_RD: mem_re=1 held until the cycle mem_ready=1, then -> WB_MEM. No timeout.
- MEM_WR: mem_we=1 held until mem_ready=1, then -> FETCH. mem_ready outside MEM_RD/MEM_WR is ignored.
- WB_MEM: we_RF=1, result_src=1, one cycle -> FETCH.
- BRANCH: pc_load=1, alu_src_b=1, alu_ctrl=ADD, one cycle -> FETCH.
- Outputs decoded from state (Moore), except ir_we/pc_en, which depend on the wait counter.
- Decode inputs are sampled only in DECODE/EXEC/MEM_ADR and are held stable by the instruction register.
- Latencies with FETCH_WAIT=1, in cycles: data-proc 5, CMP 4, LDR 6+extra ready waits, STR 5+waits, branch 4, condition-fail 3.

Test Plan:
1. Reset held 3 cycles then released, ADD (cond=1110, op=00, opcode=0100, S=0) -> states FETCH,FETCH,DECODE,EXEC,WB_ALU; ir_we/pc_en at cycle 2; we_RF at cycle 5; flags stay 0000.
2. SUBS with alu_flags=0100 (Z), then BEQ (cond=0000, op=10) -> flags=0100 after EXEC; BRANCH state entered with pc_load=1 for exactly one cycle; BNE instead returns to FETCH after DECODE with no pc_load.
3. LDR (op=01, L=1) with mem_ready delayed 3 cycles -> mem_re high 4 cycles, then WB_MEM with we_RF=1, result_src=1; total 9 cycles.
4. STR (L=0) with mem_ready=1 immediately -> mem_we one cycle; we_RF never asserted; back in FETCH.
5. op=11, then cond=1111, then MOV with rd=15 -> illegal pulses once each; no we_RF/mem_we/pc_load asserted.
6. rst asserted during MEM_RD and during EXEC with S=1 -> immediate FETCH, flags=0000, all enables 0; FETCH_WAIT=0 build gives data-proc in 4 cycles.
